// File: rtl/reflet_uart_arb_pick.sv
// Round-robin picker shared by arbiters in front of single-user peripherals.
// Purely combinational: the caller registers the result.
module reflet_uart_arb_pick #(
  parameter int unsigned nb_req = 4
) (
  input  logic [nb_req-1:0]         req,
  input  logic [$clog2(nb_req)-1:0] last_grant,
  output logic [$clog2(nb_req)-1:0] winner,
  output logic                      found
);

  localparam int unsigned id_w = $clog2(nb_req);

  logic [id_w-1:0] idx;

  // Scan last_grant+1, last_grant+2, ... modulo nb_req; the first request seen wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= nb_req; k++) begin
      idx = id_w'((32'(last_grant) + k) % nb_req);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reflet_uart_tx_arbiter.sv
// Shares one reflet UART transmitter between nb_req requesters, one byte at a
// time, round-robin, with an optional per-requester lock for multi-byte messages.
module reflet_uart_tx_arbiter #(
  parameter int unsigned nb_req         = 4,
  parameter int unsigned timeout_cycles = 16384
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nb_req-1:0]         req_valid,
  input  logic [8*nb_req-1:0]       req_data,
  input  logic [nb_req-1:0]         req_lock,
  output logic [nb_req-1:0]         req_ready,
  output logic [7:0]                uart_data,
  output logic                      uart_start,
  input  logic                      uart_done,
  output logic [$clog2(nb_req)-1:0] grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned id_w  = $clog2(nb_req);
  localparam int unsigned cnt_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam bit          wd_en = (timeout_cycles != 0);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(wd_en ? timeout_cycles - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [id_w-1:0]   last_q, last_d;
  logic              lock_v_q, lock_v_d;
  logic [id_w-1:0]   lock_id_q, lock_id_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic [7:0]        data_d;
  logic [id_w-1:0]   grant_d;
  logic [nb_req-1:0] ready_d;
  logic              start_d, busy_d, timeout_d;

  logic              lock_hold;
  logic [nb_req-1:0] cand;
  logic [id_w-1:0]   pick_id;
  logic              pick_found;
  logic [7:0]        req_bytes [nb_req];

  // Unpack the flat byte bus into one byte per requester.
  for (genvar i = 0; i < nb_req; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  // A live lock narrows the candidate set to the owner alone.
  assign lock_hold = lock_v_q && req_lock[lock_id_q];
  assign cand      = lock_hold ? (req_valid & (nb_req'(1) << lock_id_q)) : req_valid;

  reflet_uart_arb_pick #(
    .nb_req (nb_req)
  ) u_pick (
    .req        (cand),
    .last_grant (last_q),
    .winner     (pick_id),
    .found      (pick_found)
  );

  // Next-state and next-output logic; timeout_err is registered on the abort
  // edge, so it shows in the cycle after the last WAIT cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    lock_v_d  = lock_v_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    data_d    = uart_data;
    grant_d   = grant_id;
    ready_d   = '0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lock_hold) lock_v_d = 1'b0;
        if (pick_found) begin
          data_d           = req_bytes[pick_id];
          grant_d          = pick_id;
          ready_d[pick_id] = 1'b1;
          state_d          = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + cnt_w'(1);
        if (uart_done) begin
          last_d    = grant_id;
          lock_v_d  = req_lock[grant_id];
          lock_id_d = grant_id;
          state_d   = IDLE;
        end else if (wd_en && (cnt_q == cnt_last)) begin
          timeout_d = 1'b1;
          lock_v_d  = 1'b0;
          last_d    = grant_id;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= id_w'(nb_req - 1);
      lock_v_q    <= 1'b0;
      lock_id_q   <= '0;
      cnt_q       <= '0;
      uart_data   <= '0;
      grant_id    <= '0;
      req_ready   <= '0;
      uart_start  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_v_q    <= lock_v_d;
      lock_id_q   <= lock_id_d;
      cnt_q       <= cnt_d;
      uart_data   <= data_d;
      grant_id    <= grant_d;
      req_ready   <= ready_d;
      uart_start  <= start_d;
      busy        <= busy_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_reflet_uart_tx_arbiter.sv
// Bench for reflet_uart_tx_arbiter: queue-based requesters, a delayed-done UART
// responder and a transaction-level arbitration model checked every cycle.
module tb_reflet_uart_tx_arbiter;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NB-1:0]   req_valid, req_lock, req_ready;
  logic [8*NB-1:0] req_data;
  logic [7:0]      uart_data;
  logic            uart_start, uart_done, busy, timeout_err;
  logic [1:0]      grant_id;
  logic [7:0]      rq_byte [NB];

  for (genvar g = 0; g < NB; g++) begin : g_pack
    assign req_data[8*g +: 8] = rq_byte[g];
  end

  reflet_uart_tx_arbiter #(.nb_req(NB), .timeout_cycles(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .uart_data   (uart_data),
    .uart_start  (uart_start),
    .uart_done   (uart_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // reference model: transaction phase, rotation pointer, lock owner
  int          m_phase = 0, m_wc = 0, m_last = 0, m_lock_id = 0, m_grant = 0;
  bit          m_lock_v = 0;
  logic [7:0]  m_data = 0;
  logic        e_start, e_busy, e_to;
  logic [NB-1:0] e_ready;

  logic [7:0] rq [NB][$];
  bit   lk_en [NB];
  bit   gate [NB];
  int   rdy_cnt [NB];
  int   done_cnt = 0, fixed_d = 5;
  bit   rnd_mode = 0;
  int   glog[$], dlog[$], scyc[$], tcyc[$], exp_g[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    bit hold;
    int c;
    e_start = 0; e_ready = '0; e_to = 0;
    if (!reset) begin
      m_phase = 0; m_last = NB - 1; m_lock_v = 0; m_lock_id = 0;
      m_grant = 0; m_data = 8'h00; m_wc = 0;
    end else begin
      case (m_phase)
        0: begin
          hold = m_lock_v && req_lock[m_lock_id];
          if (!hold) m_lock_v = 0;
          for (int k = 1; k <= NB; k++) begin
            c = (m_last + k) % NB;
            if (req_valid[c] && (!hold || c == m_lock_id)) begin
              m_grant = c; m_data = rq_byte[c]; m_phase = 1;
              e_start = 1; e_ready[c] = 1'b1;
              break;
            end
          end
        end
        1: begin m_phase = 2; m_wc = 0; end
        default: begin
          m_wc++;
          if (uart_done) begin
            m_last = m_grant; m_lock_v = req_lock[m_grant]; m_lock_id = m_grant; m_phase = 0;
          end else if (m_wc == TO) begin
            e_to = 1; m_lock_v = 0; m_last = m_grant; m_phase = 0;
          end
        end
      endcase
    end
    e_busy = (m_phase != 0);
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 9) < 7) return $urandom_range(1, 8);
    return $urandom_range(14, 20);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NB; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      req_valid[i] = (rq[i].size() != 0) && !gate[i];
      rq_byte[i]   = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
      req_lock[i]  = lk_en[i] && (rq[i].size() != 0);
    end
  endtask

  // One clock: predict, compare after the edge, then react as requesters and UART.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("uart_start",  32'(uart_start),  32'(e_start));
    check("req_ready",   32'(req_ready),   32'(e_ready));
    check("busy",        32'(busy),        32'(e_busy));
    check("timeout_err", 32'(timeout_err), 32'(e_to));
    check("grant_id",    32'(grant_id),    32'(m_grant));
    check("uart_data",   32'(uart_data),   32'(m_data));
    if (uart_start) begin
      glog.push_back(int'(grant_id)); dlog.push_back(int'(uart_data)); scyc.push_back(cyc);
    end
    if (timeout_err) tcyc.push_back(cyc);
    uart_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) uart_done = 1'b1;
    end
    if (uart_start) done_cnt = (fixed_d != 0) ? fixed_d : pick_delay();
    for (int i = 0; i < NB; i++) begin
      if (req_ready[i] && rq[i].size() != 0) begin
        void'(rq[i].pop_front());
        rdy_cnt[i]++;
      end
      if (rnd_mode) begin
        if (rq[i].size() == 0 && $urandom_range(0, 9) == 0) begin
          for (int n = $urandom_range(1, 3); n > 0; n--) rq[i].push_back(8'($urandom));
          lk_en[i] = ($urandom_range(0, 2) == 0);
        end
        gate[i] = ($urandom_range(0, 15) == 0);
      end
    end
    if (rnd_mode) reset = ($urandom_range(0, 199) != 0);
    drive();
  endtask

  task automatic clear_logs();
    glog.delete(); dlog.delete(); scyc.delete(); tcyc.delete();
    for (int i = 0; i < NB; i++) rdy_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    uart_done = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      rq[i].delete(); lk_en[i] = 0; gate[i] = 0;
    end
    drive();
    cycle();
    cycle();
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic run_idle(input string tag);
    bit ok = 0;
    for (int n = 0; n < 800; n++) begin
      if (pending() == 0 && m_phase == 0 && done_cnt == 0 && reset) begin
        ok = 1;
        break;
      end
      cycle();
    end
    check({tag, "_drain_bound"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_grants(input string tag);
    check({tag, "_count"}, 32'(glog.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), (i < glog.size()) ? 32'(glog[i]) : 32'hffff_ffff,
            32'(exp_g[i]));
  endtask

  initial begin
    reset = 1'b0;
    uart_done = 1'b0;
    for (int i = 0; i < NB; i++) rq_byte[i] = 8'h00;
    req_valid = '0; req_lock = '0;

    // single byte from requester 0
    do_reset();
    check("rst_start", 32'(uart_start), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ready", 32'(req_ready),  32'd0);
    check("rst_grant", 32'(grant_id),   32'd0);
    check("rst_data",  32'(uart_data),  32'd0);
    fixed_d = 3;
    rq[0].push_back(8'h41);
    drive();
    cycle();
    check("t1_start", 32'(uart_start), 32'd1);
    check("t1_data",  32'(uart_data),  32'h41);
    check("t1_ready", 32'(req_ready),  32'b0001);
    run_idle("t1");
    check("t1_busy",  32'(busy),     32'd0);
    check("t1_grant", 32'(grant_id), 32'd0);

    // all four busy: pure rotation
    do_reset();
    fixed_d = 5;
    for (int i = 0; i < NB; i++) begin
      rq[i].push_back(8'(8'h20 + i)); rq[i].push_back(8'(8'h30 + i));
    end
    drive();
    run_idle("t2");
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_grants("t2");
    for (int i = 0; i < NB; i++) check($sformatf("t2_ready_cnt%0d", i), 32'(rdy_cnt[i]), 32'd2);

    // locked three-byte message from requester 2
    do_reset();
    rq[2].push_back(8'h10); rq[2].push_back(8'h11); rq[2].push_back(8'h12);
    lk_en[2] = 1;
    drive();
    cycle();
    rq[0].push_back(8'hA0); rq[1].push_back(8'hA1); rq[3].push_back(8'hA3);
    drive();
    run_idle("t3");
    exp_g = '{2, 2, 2, 3, 0, 1};
    chk_grants("t3");
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_data%0d", i), (i < dlog.size()) ? 32'(dlog[i]) : 32'hffff_ffff,
            32'(8'h10 + i));

    // watchdog expiry, then service of the next requester
    do_reset();
    fixed_d = 40;
    rq[1].push_back(8'h51); rq[2].push_back(8'h52);
    drive();
    run_idle("t4");
    exp_g = '{1, 2};
    chk_grants("t4");
    check("t4_timeouts", 32'(tcyc.size()), 32'd2);
    if (tcyc.size() > 0 && scyc.size() > 1) begin
      check("t4_to_latency",  32'(tcyc[0] - scyc[0]), 32'd17);
      check("t4_next_start",  32'(scyc[1] - scyc[0]), 32'd18);
    end
    // stray done arrives after the abort, while idle
    clear_logs();
    fixed_d = 20;
    rq[3].push_back(8'h53);
    drive();
    run_idle("t4s");
    exp_g = '{3};
    chk_grants("t4s");
    check("t4s_timeouts", 32'(tcyc.size()), 32'd1);
    check("t4s_busy",     32'(busy),        32'd0);

    // done coincides with the last watchdog cycle
    do_reset();
    fixed_d = 16;
    rq[0].push_back(8'h77);
    drive();
    run_idle("t5");
    exp_g = '{0};
    chk_grants("t5");
    check("t5_timeouts", 32'(tcyc.size()), 32'd0);

    // reset during WAIT
    do_reset();
    fixed_d = 10;
    rq[1].push_back(8'h55);
    drive();
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b0;
    cycle();
    check("t6_busy",  32'(busy),       32'd0);
    check("t6_start", 32'(uart_start), 32'd0);
    check("t6_ready", 32'(req_ready),  32'd0);
    reset = 1'b1;
    clear_logs();
    fixed_d = 4;
    for (int i = 0; i < NB; i++) rq[i].push_back(8'(8'h60 + i));
    drive();
    run_idle("t6");
    exp_g = '{0, 1, 2, 3};
    chk_grants("t6");

    // randomized traffic against the model
    do_reset();
    fixed_d = 0;
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) cycle();
    rnd_mode = 0;
    reset = 1'b1;
    for (int i = 0; i < NB; i++) gate[i] = 0;
    drive();
    run_idle("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
